// File: rtl/mem_stage_ctrl_pkg.sv
// cpu_pkg: shared types and defaults for the MEM-stage memory access controller.
//   mem_ctrl_state_t : controller state encoding (IDLE, BUSY, DONE)
//   DATA_W_DEFAULT   : default data/address width of the 16-bit CPU
package cpu_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: req/ack handshake bus between the MEM-stage controller
// and the variable-latency data memory.
//   dmem_req   : request, held high until dmem_ack (master -> slave)
//   dmem_we    : 1 = write, 0 = read, valid with dmem_req (master -> slave)
//   dmem_addr  : access address (master -> slave)
//   dmem_wdata : store data (master -> slave)
//   dmem_ack   : one-cycle completion pulse (slave -> master)
//   dmem_rdata : read data, valid with dmem_ack (slave -> master)
interface mem_stage_ctrl_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_wait_timer.sv
// wait_timer: clearable up-counter with terminal-count flag, used as the
// watchdog that bounds how long a memory request may wait for its ack.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear_i    : synchronous clear to zero (has priority over en_i)
//   en_i       : count up by one per cycle
//   tc_o       : high while the count equals TIMEOUT-1
module wait_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o = (count_q == W'(TIMEOUT - 1));

  // Next count: clear wins, otherwise count up and hold at the terminal
  // value so a missed abort can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences data-memory accesses for the MEM stage.
// While an access is outstanding it stalls the upstream pipeline and feeds
// bubbles (RegWrite=0) into MEM/WB; load data is presented for exactly one
// retire cycle (DONE). A watchdog turns a hung memory into a sticky error.
//   clk, rst_n       : clock and asynchronous active-low reset
//   mem_read_m_i     : instruction in MEM is a load
//   mem_write_m_i    : instruction in MEM is a store (wins over a load)
//   reg_write_m_i    : RegWrite of the instruction in MEM
//   addr_m_i         : memory address
//   wdata_m_i        : store data
//   dmem             : req/ack bus to data memory (master side)
//   stall_o          : hold IF/ID, ID/EX, EX/MEM and PC
//   reg_write_mw_o   : gated RegWrite into MEM/WB
//   read_data_m_o    : load data into MEM/WB
//   timeout_err_o    : sticky watchdog abort flag
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_m_i,
  input  logic              mem_write_m_i,
  input  logic              reg_write_m_i,
  input  logic [DATA_W-1:0] addr_m_i,
  input  logic [DATA_W-1:0] wdata_m_i,
  mem_stage_ctrl_if.master  dmem,
  output logic              stall_o,
  output logic              reg_write_mw_o,
  output logic [DATA_W-1:0] read_data_m_o,
  output logic              timeout_err_o
);

  mem_ctrl_state_t   state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;

  logic memOp;
  logic timerClear;
  logic timerEn;
  logic timerTc;

  assign memOp = mem_read_m_i | mem_write_m_i;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign read_data_m_o   = rdata_q;
  assign timeout_err_o   = err_q;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (timerClear),
    .en_i    (timerEn),
    .tc_o    (timerTc)
  );

  // Next-state and output logic. The bus registers are only loaded on the
  // IDLE->BUSY transition, so they stay stable for the whole request. An ack
  // is tested before the terminal count so a same-cycle ack wins. DONE goes
  // straight back to IDLE so the instruction still visible on the inputs is
  // not issued twice.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    abort_d        = abort_q;
    stall_o        = 1'b0;
    reg_write_mw_o = 1'b0;
    timerClear     = 1'b0;
    timerEn        = 1'b0;

    case (state_q)
      IDLE: begin
        if (memOp) begin
          stall_o    = 1'b1;
          addr_d     = addr_m_i;
          wdata_d    = wdata_m_i;
          we_d       = mem_write_m_i;
          req_d      = 1'b1;
          abort_d    = 1'b0;
          timerClear = 1'b1;
          state_d    = BUSY;
        end else begin
          reg_write_mw_o = reg_write_m_i;
        end
      end

      BUSY: begin
        stall_o = 1'b1;
        timerEn = 1'b1;
        if (dmem.dmem_ack) begin
          if (!we_q) begin
            rdata_d = dmem.dmem_rdata;
          end
          req_d   = 1'b0;
          abort_d = 1'b0;
          state_d = DONE;
        end else if (timerTc) begin
          err_d   = 1'b1;
          rdata_d = '0;
          req_d   = 1'b0;
          abort_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        reg_write_mw_o = reg_write_m_i & ~mem_write_m_i & ~abort_q;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and bus registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl. The driver issues
// one instruction at a time, plays the data memory, and pushes the expected
// retire result and expected memory request into queues computed from the
// instruction-level rules. Two monitors pop and compare independently.
module tb_mem_stage_ctrl;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic              rw;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                stalls;
  } retire_t;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                len;
  } req_t;

  logic              clk;
  logic              rst_n;
  logic              mem_read_m;
  logic              mem_write_m;
  logic              reg_write_m;
  logic [DATA_W-1:0] addr_m;
  logic [DATA_W-1:0] wdata_m;
  logic              stall;
  logic              reg_write_mw;
  logic [DATA_W-1:0] read_data_m;
  logic              timeout_err;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmemIf ();

  mem_stage_ctrl #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_m_i   (mem_read_m),
    .mem_write_m_i  (mem_write_m),
    .reg_write_m_i  (reg_write_m),
    .addr_m_i       (addr_m),
    .wdata_m_i      (wdata_m),
    .dmem           (dmemIf),
    .stall_o        (stall),
    .reg_write_mw_o (reg_write_mw),
    .read_data_m_o  (read_data_m),
    .timeout_err_o  (timeout_err)
  );

  int checks = 0;
  int errors = 0;

  retire_t retireQ[$];
  req_t    reqQ[$];
  logic    monEnable;

  logic [DATA_W-1:0] modelRead;
  logic              modelErr;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something deadlocks outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one instruction into MEM, record what should happen, act as the
  // memory (ack j cycles after the request rises, none if j >= TIMEOUT),
  // then wait for the instruction to retire.
  task automatic applyStimulus(input logic rd, input logic wr, input logic rw,
                               input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                               input logic [DATA_W-1:0] rdata, input int j);
    retire_t r;
    req_t    q;
    logic    isMem;
    int      budget;
    isMem = rd | wr;
    @(posedge clk);
    #1;
    mem_read_m  = rd;
    mem_write_m = wr;
    reg_write_m = rw;
    addr_m      = addr;
    wdata_m     = wdata;
    if (!isMem) begin
      r.rw     = rw;
      r.rdata  = modelRead;
      r.err    = modelErr;
      r.stalls = 0;
    end else begin
      q.we    = wr;
      q.addr  = addr;
      q.wdata = wdata;
      if (j < TIMEOUT) begin
        if (!wr) modelRead = rdata;
        r.rw     = rw & ~wr;
        r.err    = modelErr;
        r.stalls = j + 2;
        q.len    = j + 1;
      end else begin
        modelErr  = 1'b1;
        modelRead = '0;
        r.rw      = 1'b0;
        r.err     = 1'b1;
        r.stalls  = TIMEOUT + 1;
        q.len     = TIMEOUT;
      end
      r.rdata = modelRead;
      reqQ.push_back(q);
    end
    retireQ.push_back(r);
    monEnable = 1'b1;
    if (isMem && j < TIMEOUT) begin
      repeat (j + 1) begin
        @(posedge clk);
        #1;
      end
      dmemIf.dmem_ack   = 1'b1;
      dmemIf.dmem_rdata = rdata;
      @(posedge clk);
      #1;
      dmemIf.dmem_ack   = 1'b0;
      dmemIf.dmem_rdata = 16'($urandom);
    end
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (stall && budget < 40);
    if (stall) checkOutput("retire_wait_budget", 32'(stall), 32'd0);
  endtask

  // Retire monitor: every cycle with stall low is one instruction leaving MEM.
  int   stallCount = 0;
  logic rwInStall  = 1'b0;
  always @(negedge clk) begin
    retire_t e;
    if (!monEnable) begin
      stallCount = 0;
      rwInStall  = 1'b0;
    end else if (stall) begin
      stallCount++;
      if (reg_write_mw) rwInStall = 1'b1;
    end else begin
      if (retireQ.size() == 0) begin
        checkOutput("unexpected_retire", 32'd1, 32'd0);
      end else begin
        e = retireQ.pop_front();
        checkOutput("retire_stall_cycles", 32'(stallCount), 32'(e.stalls));
        checkOutput("retire_reg_write", 32'(reg_write_mw), 32'(e.rw));
        checkOutput("retire_read_data", 32'(read_data_m), 32'(e.rdata));
        checkOutput("retire_timeout_err", 32'(timeout_err), 32'(e.err));
        checkOutput("reg_write_while_stalled", 32'(rwInStall), 32'd0);
      end
      stallCount = 0;
      rwInStall  = 1'b0;
    end
  end

  // Request monitor: each rising dmem_req is one memory episode.
  logic              inReq = 1'b0;
  int                reqLen = 0;
  logic              reqStable = 1'b1;
  req_t              curReq;
  logic              snapWe;
  logic [DATA_W-1:0] snapAddr;
  logic [DATA_W-1:0] snapWdata;
  always @(negedge clk) begin
    if (!monEnable) begin
      inReq = 1'b0;
    end else if (dmemIf.dmem_req && !inReq) begin
      inReq     = 1'b1;
      reqLen    = 1;
      reqStable = 1'b1;
      snapWe    = dmemIf.dmem_we;
      snapAddr  = dmemIf.dmem_addr;
      snapWdata = dmemIf.dmem_wdata;
      if (reqQ.size() == 0) begin
        curReq.len = 0;
        checkOutput("unexpected_req", 32'd1, 32'd0);
      end else begin
        curReq = reqQ.pop_front();
        checkOutput("req_we", 32'(dmemIf.dmem_we), 32'(curReq.we));
        checkOutput("req_addr", 32'(dmemIf.dmem_addr), 32'(curReq.addr));
        checkOutput("req_wdata", 32'(dmemIf.dmem_wdata), 32'(curReq.wdata));
      end
    end else if (dmemIf.dmem_req && inReq) begin
      reqLen++;
      if (dmemIf.dmem_we !== snapWe || dmemIf.dmem_addr !== snapAddr ||
          dmemIf.dmem_wdata !== snapWdata) reqStable = 1'b0;
    end else if (!dmemIf.dmem_req && inReq) begin
      inReq = 1'b0;
      checkOutput("req_length", 32'(reqLen), 32'(curReq.len));
      checkOutput("req_stable", 32'(reqStable), 32'd1);
    end
  end

  // Main sequence: reset, directed cases, random traffic, mid-access reset.
  initial begin
    int kind;
    int j;
    rst_n             = 1'b0;
    mem_read_m        = 1'b0;
    mem_write_m       = 1'b0;
    reg_write_m       = 1'b0;
    addr_m            = '0;
    wdata_m           = '0;
    dmemIf.dmem_ack   = 1'b0;
    dmemIf.dmem_rdata = '0;
    monEnable         = 1'b0;
    modelRead         = '0;
    modelErr          = 1'b0;

    #12;
    checkOutput("reset_req", 32'(dmemIf.dmem_req), 32'd0);
    checkOutput("reset_we", 32'(dmemIf.dmem_we), 32'd0);
    checkOutput("reset_addr", 32'(dmemIf.dmem_addr), 32'd0);
    checkOutput("reset_wdata", 32'(dmemIf.dmem_wdata), 32'd0);
    checkOutput("reset_read_data", 32'(read_data_m), 32'd0);
    checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1112, 16'h2223, 16'h3334, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h5555, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'hA5A5, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0102, 16'h7777, 16'h0000, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'hCAFE, TIMEOUT);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0202, 16'h0000, 16'h0F0F, TIMEOUT - 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0204, 16'h4321, 16'h9999, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) j = TIMEOUT;
      else j = int'($urandom_range(0, TIMEOUT - 1));
      applyStimulus(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), 16'($urandom), j);
    end

    @(posedge clk);
    #1;
    monEnable   = 1'b0;
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    reg_write_m = 1'b0;

    // Reset in the second BUSY cycle of a load.
    @(posedge clk);
    #1;
    mem_read_m  = 1'b1;
    reg_write_m = 1'b1;
    addr_m      = 16'h0077;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("busy_req_before_reset", 32'(dmemIf.dmem_req), 32'd1);
    checkOutput("sticky_err_before_reset", 32'(timeout_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_req", 32'(dmemIf.dmem_req), 32'd0);
    checkOutput("async_reset_addr", 32'(dmemIf.dmem_addr), 32'd0);
    checkOutput("async_reset_read_data", 32'(read_data_m), 32'd0);
    checkOutput("async_reset_timeout_err", 32'(timeout_err), 32'd0);
    mem_read_m  = 1'b0;
    reg_write_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dmemIf.dmem_ack   = 1'b1;
    dmemIf.dmem_rdata = 16'hDEAD;
    @(posedge clk);
    #1;
    dmemIf.dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_req", 32'(dmemIf.dmem_req), 32'd0);
    checkOutput("late_ack_read_data", 32'(read_data_m), 32'd0);
    checkOutput("late_ack_stall", 32'(stall), 32'd0);

    modelRead = '0;
    modelErr  = 1'b0;
    retireQ.delete();
    reqQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h1357, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0302, 16'h2468, 16'h0000, 0);
    @(posedge clk);
    #1;
    monEnable   = 1'b0;
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    reg_write_m = 1'b0;

    checkOutput("retire_queue_drained", 32'(retireQ.size()), 32'd0);
    checkOutput("req_queue_drained", 32'(reqQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Sequences data-memory accesses in the MEM stage of the 16-bit pipelined CPU, using a req/ack handshake with variable-latency data memory.
- While an access is outstanding it stalls all upstream pipeline registers.
- It forces RegWrite low into the MEM/WB register, so WB sees bubbles.
- It presents captured load data to MEM/WB for exactly one retire cycle.
- A timeout watchdog turns a hung memory into a sticky error instead of a deadlock.

Parameters:
DATA_W, 16, data and address width in bits
TIMEOUT, 64, maximum BUSY cycles without dmem_ack before abort (minimum 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_read_m  in  1  instruction in MEM is a load
mem_write_m  in  1  instruction in MEM is a store
reg_write_m  in  1  RegWrite of instruction in MEM
addr_m  in  DATA_W  ALU result used as memory address
wdata_m  in  DATA_W  store data
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = write, 0 = read; valid with dmem_req
dmem_addr  out  DATA_W  latched address
dmem_wdata  out  DATA_W  latched store data
dmem_ack  in  1  one-cycle completion pulse from memory
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
stall  out  1  hold IF/ID, ID/EX, EX/MEM, PC
reg_write_mw  out  1  gated RegWrite into MEM/WB
read_data_m  out  DATA_W  load data into MEM/WB
timeout_err  out  1  sticky abort flag

Behaviour:
- States: IDLE, BUSY, DONE. Encoding is a shared enum.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, read_data_m=0, timeout_err=0, timer=0.
  - An access in flight is abandoned; any late dmem_ack is ignored.
- mem_op = mem_read_m | mem_write_m. If both are set, treat as a write.
- IDLE:
  - mem_op=0: stall=0, reg_write_mw=reg_write_m.
  - mem_op=1: stall=1, reg_write_mw=0. Latch addr_m, wdata_m and we into the dmem_* registers, clear timer, go to BUSY.
- BUSY:
  - dmem_req=1, stall=1, reg_write_mw=0. Timer increments each cycle.
  - dmem_ack=1: capture dmem_rdata into read_data_m (reads only; stores leave it unchanged), drop dmem_req at the next edge, go to DONE.
  - Timer reaches TIMEOUT-1 without ack: set timeout_err, set read_data_m=0, go to DONE with the abort flag set.
  - An ack and the timeout in the same cycle: the ack wins.
- DONE (exactly one cycle):
  - dmem_req=0, stall=0, so the pipeline advances and MEM/WB captures.
  - reg_write_mw = reg_write_m & ~mem_write_m & ~abort.
  - Next state is always IDLE. DONE never re-triggers on the instruction still visible on its inputs.
- Latency: op appears in cycle 0 and dmem_req rises in cycle 1. With ack in cycle 1+j (j>=0), DONE is cycle 2+j. The instruction occupies MEM for 3+j cycles; stall is high in cycles 0..1+j.
- Back-to-back ops: the following instruction enters MEM after DONE and is handled from IDLE. There is no overlap, and at most one outstanding request.
- dmem_ack outside BUSY is ignored.
- dmem_addr, dmem_wdata and dmem_we are stable for the whole time dmem_req=1.
- timeout_err stays set until reset. Later accesses still proceed normally.

Decomposition:
- Package cpu_pkg holds:
  - typedef enum logic [1:0] mem_ctrl_state_t {IDLE, BUSY, DONE};
  - localparam DATA_W_DEFAULT = 16.
- One sub-module, wait_timer: a clearable up-counter with terminal-count output. Width is $clog2(TIMEOUT), and the same async active-low reset is used.

Test Plan:
- ALU op (reg_write_m=1, no mem op) → stall=0, reg_write_mw=1 every cycle, dmem_req never asserted.
- Load at addr 0x0040, ack 3 cycles after req with rdata 0xBEEF:
  - stall high for 5 cycles;
  - read_data_m=0xBEEF and reg_write_mw=1 in the DONE cycle only;
  - dmem_addr=0x0040 throughout the request.
- Store 0x1234 to 0x0010 with ack in the same cycle as req → dmem_we=1, stall high 2 cycles, reg_write_mw=0 in DONE, read_data_m unchanged.
- Load followed by store back-to-back → two separate req/ack episodes, IDLE between DONE and the second req, no dropped or merged access.
- TIMEOUT=8, no ack:
  - dmem_req high 8 cycles, then drops;
  - timeout_err=1, read_data_m=0, reg_write_mw=0, stall released for one DONE cycle;
  - timeout_err remains set through subsequent accesses.
- reset pulled low in cycle 2 of BUSY → dmem_req=0 immediately (asynchronous), all outputs at reset values. A late dmem_ack after release is ignored, and the next op starts cleanly from IDLE.
